// File: rtl/unidade_controle_multiciclo.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : unidade_controle_multiciclo                                 |
// | Purpose : Multi-cycle control unit for the 8-bit accumulator CPU.     |
// |           Sequences FETCH/DECODE/(MEM)/EXEC, drives datapath strobes, |
// |           provides run/halt control and a retired-instruction count.  |
// | Rev     : 1.0  initial release                                        |
// +-----------------------------------------------------------------------+
module unidade_controle_multiciclo (
   input  logic       clock_i,
   input  logic       reset_ni,
   input  logic       run_i,
   input  logic [3:0] opcode_i,
   input  logic [7:0] ac_in_i,
   output logic       ld_ac_o,
   output logic       ac_src_o,
   output logic       pc_src_o,
   output logic       pc_ld_o,
   output logic       dm_we_o,
   output logic       halted_o,
   output logic [2:0] state_o,
   output logic [7:0] retired_o
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      MEM    = 3'd3,
      EXEC   = 3'd4,
      HALT   = 3'd5
   } state_t;

   localparam logic [3:0] OP_LDA = 4'b0001;
   localparam logic [3:0] OP_STA = 4'b0010;
   localparam logic [3:0] OP_JMP = 4'b1000;
   localparam logic [3:0] OP_JZ  = 4'b1001;
   localparam logic [3:0] OP_HLT = 4'b1111;

   state_t     state_q, state_d;
   logic [7:0] retired_q;
   logic       needs_mem;
   logic       is_alu;

   // Classify the opcode: ALU ops and LDA need a data-memory read cycle.
   always_comb begin
      is_alu    = (opcode_i >= 4'b0011) && (opcode_i <= 4'b0111);
      needs_mem = is_alu || (opcode_i == OP_LDA);
   end

   // State register and retired counter; counter steps on every edge leaving EXEC.
   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q   <= IDLE;
         retired_q <= 8'd0;
      end else begin
         state_q <= state_d;
         if (state_q == EXEC) begin
            retired_q <= retired_q + 8'd1;
         end
      end
   end

   // Next-state logic and combinational strobes decoded from state and opcode.
   always_comb begin
      state_d  = state_q;
      ld_ac_o  = 1'b0;
      ac_src_o = 1'b0;
      pc_src_o = 1'b0;
      pc_ld_o  = 1'b0;
      dm_we_o  = 1'b0;
      halted_o = 1'b0;
      case (state_q)
         IDLE:    state_d = run_i ? FETCH : IDLE;
         FETCH:   state_d = DECODE;
         DECODE:  state_d = needs_mem ? MEM : EXEC;
         MEM:     state_d = EXEC;
         EXEC: begin
            if (opcode_i == OP_HLT) begin
               state_d = HALT;
            end else begin
               state_d = run_i ? FETCH : IDLE;
            end
            case (opcode_i)
               OP_LDA: begin
                  ld_ac_o  = 1'b1;
                  ac_src_o = 1'b1;
                  pc_ld_o  = 1'b1;
               end
               OP_STA: begin
                  dm_we_o = 1'b1;
                  pc_ld_o = 1'b1;
               end
               4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b0111: begin
                  ld_ac_o = 1'b1;
                  pc_ld_o = 1'b1;
               end
               OP_JMP: begin
                  pc_ld_o  = 1'b1;
                  pc_src_o = 1'b1;
               end
               OP_JZ: begin
                  pc_ld_o  = 1'b1;
                  pc_src_o = (ac_in_i == 8'h00);
               end
               OP_HLT:  ; // PC stays on the HLT address
               default: pc_ld_o = 1'b1;
            endcase
         end
         HALT: begin
            state_d  = HALT;
            halted_o = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   assign state_o   = state_q;
   assign retired_o = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_unidade_controle_multiciclo.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : tb_unidade_controle_multiciclo                              |
// | Purpose : Self-checking bench with an instruction-level model.        |
// | Rev     : 1.0  initial release                                        |
// +-----------------------------------------------------------------------+
module tb_unidade_controle_multiciclo;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       run = 1'b0;
   logic [3:0] opcode = 4'd0;
   logic [7:0] ac_in = 8'd0;
   logic       ld_ac, ac_src, pc_src, pc_ld, dm_we, halted;
   logic [2:0] state;
   logic [7:0] retired;

   int n_checks = 0;
   int n_fail   = 0;

   unidade_controle_multiciclo dut (
      .clock_i  (clk),
      .reset_ni (rst_n),
      .run_i    (run),
      .opcode_i (opcode),
      .ac_in_i  (ac_in),
      .ld_ac_o  (ld_ac),
      .ac_src_o (ac_src),
      .pc_src_o (pc_src),
      .pc_ld_o  (pc_ld),
      .dm_we_o  (dm_we),
      .halted_o (halted),
      .state_o  (state),
      .retired_o(retired)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model: instruction progress --------------
   bit         m_idle = 1'b1;
   bit         m_halt = 1'b0;
   int         m_step = 0;     // cycle index inside the current instruction
   logic [7:0] m_ret  = 8'd0;

   function automatic bit uses_mem(input logic [3:0] op);
      return (op == 4'd1) || (op >= 4'd3 && op <= 4'd7);
   endfunction

   // index of the execute cycle: fetch, decode, [memory], execute
   function automatic int exec_step(input logic [3:0] op);
      return uses_mem(op) ? 3 : 2;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_idle = 1'b1; m_halt = 1'b0; m_step = 0; m_ret = 8'd0;
      end else if (!m_halt) begin
         if (m_idle) begin
            if (run) begin m_idle = 1'b0; m_step = 0; end
         end else if (m_step < exec_step(opcode)) begin
            m_step++;
         end else begin
            m_ret = m_ret + 8'd1;
            if (opcode == 4'hF) m_halt = 1'b1;
            else if (!run)      m_idle = 1'b1;
            else                m_step = 0;
         end
      end
   end

   function automatic int model_state();
      if (m_halt) return 5;
      if (m_idle) return 0;
      if (m_step == 0) return 1;
      if (m_step == 1) return 2;
      if (m_step == exec_step(opcode)) return 4;
      return 3;
   endfunction

   // Compare every cycle on the falling edge, away from the active edge.
   always @(negedge clk) begin
      int  es;
      bit  ex;
      es = model_state();
      ex = (es == 4);
      check("state",   32'(state),   32'(es));
      check("retired", 32'(retired), 32'(m_ret));
      check("halted",  32'(halted),  32'(es == 5));
      check("ld_ac",   32'(ld_ac),   32'(ex && uses_mem(opcode)));
      check("ac_src",  32'(ac_src),  32'(ex && opcode == 4'd1));
      check("dm_we",   32'(dm_we),   32'(ex && opcode == 4'd2));
      check("pc_ld",   32'(pc_ld),   32'(ex && opcode != 4'hF));
      check("pc_src",  32'(pc_src),  32'(ex && (opcode == 4'd8 || (opcode == 4'd9 && ac_in == 8'd0))));
   end

   // ---------------- directed helpers ------------------------------------
   task automatic step_cycle();
      @(posedge clk); #1;
   endtask

   // Runs one instruction from FETCH, checking literal states and EXEC strobes
   // {ld_ac, ac_src, pc_src, pc_ld, dm_we}; returns back in FETCH.
   task automatic lit_instr(input logic [3:0] op, input logic [7:0] ac,
                            input bit mem, input logic [4:0] strb);
      opcode = op; ac_in = ac;
      step_cycle(); check("lit_decode", 32'(state), 32'd2);
      if (mem) begin step_cycle(); check("lit_mem", 32'(state), 32'd3); end
      step_cycle(); check("lit_exec", 32'(state), 32'd4);
      check("lit_strobes", 32'({ld_ac, ac_src, pc_src, pc_ld, dm_we}), 32'(strb));
      step_cycle(); check("lit_refetch", 32'(state), 32'd1);
   endtask

   task automatic wait_model(input int st, input int budget);
      int k;
      k = 0;
      while (model_state() != st && k < budget) begin step_cycle(); k++; end
      check("wait_bound", 32'(k < budget), 32'd1);
   endtask

   initial begin
      logic [7:0] r0;
      // reset / idle
      #2;
      check("rst_state", 32'(state), 32'd0);
      check("rst_retired", 32'(retired), 32'd0);
      check("rst_strobes", 32'({ld_ac, ac_src, pc_src, pc_ld, dm_we, halted}), 32'd0);
      rst_n = 1'b1;
      repeat (5) step_cycle();
      check("idle_state", 32'(state), 32'd0);
      check("idle_retired", 32'(retired), 32'd0);
      opcode = 4'd1; run = 1'b1;
      step_cycle(); check("first_fetch", 32'(state), 32'd1);

      // LDA, STA, ADD, JZ taken / not taken
      lit_instr(4'd1, 8'h33, 1'b1, 5'b11010);
      check("lda_retired", 32'(retired), 32'd1);
      lit_instr(4'd2, 8'h33, 1'b0, 5'b00011);
      lit_instr(4'd3, 8'h33, 1'b1, 5'b10010);
      lit_instr(4'd9, 8'h00, 1'b0, 5'b00110);
      lit_instr(4'd9, 8'h05, 1'b0, 5'b00010);
      lit_instr(4'd8, 8'h05, 1'b0, 5'b00110);
      lit_instr(4'hC, 8'h05, 1'b0, 5'b00010);
      check("seq_retired", 32'(retired), 32'd7);

      // randomized traffic with occasional asynchronous resets
      for (int c = 0; c < 1500; c++) begin
         @(posedge clk); #1;
         ac_in = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
         run   = ($urandom_range(0, 3) != 0);
         if (m_idle || m_step == 0) opcode = 4'($urandom_range(0, 14));
         #2;
         if (!rst_n) rst_n = 1'b1;
         else if ($urandom_range(0, 80) == 0) rst_n = 1'b0;
      end
      #2 rst_n = 1'b1;

      // 255 NOPs then HLT: counter wraps on the HLT
      @(posedge clk); #2 rst_n = 1'b0; #2 rst_n = 1'b1;
      opcode = 4'd0; run = 1'b1;
      r0 = 8'd0;
      for (int k = 0; k < 1000 && !(m_ret == 8'd255 && !m_idle && m_step == 0); k++) step_cycle();
      check("pre_hlt_retired", 32'(retired), 32'd255);
      opcode = 4'hF;
      wait_model(5, 10);
      repeat (4) begin
         step_cycle();
         check("halt_state", 32'(state), 32'd5);
         check("halt_flag", 32'(halted), 32'd1);
         check("halt_pc_ld", 32'(pc_ld), 32'd0);
         check("wrap_retired", 32'(retired), 32'(r0));
      end
      #2 rst_n = 1'b0; #1;
      check("async_state", 32'(state), 32'd0);
      check("async_retired", 32'(retired), 32'd0);

      // async reset mid-EXEC of STA
      @(posedge clk); #2 rst_n = 1'b1;
      opcode = 4'd2; run = 1'b1;
      wait_model(4, 10);
      check("sta_dm_we", 32'(dm_we), 32'd1);
      #1 rst_n = 1'b0; #1;
      check("sta_dm_drop", 32'(dm_we), 32'd0);
      check("sta_state0", 32'(state), 32'd0);

      // run dropped during DECODE: ADD finishes then parks
      @(posedge clk); #2 rst_n = 1'b1;
      opcode = 4'd3; run = 1'b1;
      wait_model(2, 10);
      run = 1'b0;
      repeat (4) step_cycle();
      check("park_state", 32'(state), 32'd0);
      check("park_retired", 32'(retired), 32'd1);
      repeat (3) step_cycle();
      check("park_stay", 32'(state), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
